dram_bscan_chain_ctl: RTL
=========================

Name: dram_bscan_chain_ctl

Overview:
Boundary-scan chain controller for the DRAM SSTL pad ring. It is the initiator that drives the per-pad bscan cells' control and serial inputs (clock_dr, shift_dr, update_dr, mode_ctrl, hiz_n, bsi) and collects the chain's serial output (bso). A host issues one capture/shift/update transaction at a time, writing CHAIN_LEN bits and reading CHAIN_LEN captured bits. The block sits between the DRAM controller test/debug logic and the first pad of the chain.

Parameters:
CHAIN_LEN, 16, number of bscan cells in the chain (min 1)
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
clk  input  1  block clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle transaction request; accepted only when busy=0
capture_en  input  1  perform capture phase before shifting (sampled with start)
update_en  input  1  perform update phase after shifting (sampled with start)
wdata  input  CHAIN_LEN  data to shift in; wdata[0] shifted first (sampled with start)
ext_test  input  1  level; requested value for mode_ctrl
hiz_req  input  1  level; 1 requests the pads tri-stated
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
rdata  output  CHAIN_LEN  bits read from bso; valid from done, held until next start
clock_dr  output  1  scan data-register clock to cells; cells act on its rising edge
shift_dr  output  1  1 = cells shift, 0 = cells capture
update_dr  output  1  update strobe to cells
mode_ctrl  output  1  cell mode select (1 = external test)
hiz_n  output  1  active-low pad tri-state
bsi  output  1  serial data into chain
bso  input  1  serial data out of chain

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; busy=0, done=0, rdata=0, clock_dr=0, shift_dr=0, update_dr=0, mode_ctrl=0, hiz_n=1, bsi=0. All outputs registered.
- States: IDLE, CAP_LO, CAP_HI, SH_LO, SH_HI, UPD, DONE.
- IDLE: start=1 -> latch wdata into shift reg, latch capture_en/update_en, clear rdata, busy=1 next cycle; go to CAP_LO if capture_en else SH_LO with bit count 0.
- CAP_LO: shift_dr=0, clock_dr=0 (1 cycle). CAP_HI: shift_dr=0, clock_dr=1 (1 cycle) -> SH_LO.
- SH_LO: shift_dr=1, clock_dr=0, bsi=wreg[0]; sample bso into rdata[count]. SH_HI: shift_dr=1, clock_dr=1; wreg shifts right by 1; count+1. After SH_HI with count==CHAIN_LEN-1 -> UPD if update_en else DONE; otherwise -> SH_LO.
- UPD: shift_dr=0, clock_dr=0, update_dr=1 (1 cycle) -> DONE.
- DONE: done=1, busy=0 in the same cycle, all strobes 0 -> IDLE. A start presented in the DONE cycle is ignored; a new start is accepted in IDLE from the next cycle.
- Latency (start edge to done-high cycle): 2*CHAIN_LEN + 1 + 2*capture_en + update_en cycles.
- start while busy=1: ignored, no side effects.
- bsi holds its last value outside SH_LO/SH_HI; it is 0 after reset.
- mode_ctrl and hiz_n: registered copies of ext_test and ~hiz_req with 1-cycle latency. While busy=1 they are frozen at their values at start acceptance. Changes made mid-transaction apply the cycle after DONE.
- Reset mid-transaction: next cycle the block is in IDLE with reset outputs; no done pulse; partial rdata is discarded (cleared to 0).
- Counter: CNT_W bits, never exceeds CHAIN_LEN-1. CHAIN_LEN=1 gives a single SH_LO/SH_HI pair.

Test Plan:
- Reset: assert rst for 2 cycles mid-shift of a CHAIN_LEN=16 transaction -> next cycle all outputs at reset values, busy=0, no done; following start completes normally.
- Loopback: bench chain = 16-bit shift register clocked on clock_dr rising edge, preloaded 0xA5C3; start with capture_en=0, update_en=1, wdata=0x1234 -> rdata=0xA5C3 (rdata[0]=chain bit nearest bso); chain=0x1234; one update_dr pulse; done exactly 34 cycles after start.
- Capture: chain captures 0xFFFF on clock_dr while shift_dr=0; capture_en=1, update_en=0 -> rdata=0xFFFF, no update_dr pulse, done at 35 cycles.
- Busy rejection: second start 5 cycles after the first -> ignored; exactly one done pulse; rdata reflects only the first transaction.
- Mode/hiz: hiz_req=1, ext_test=1 at idle -> hiz_n=0, mode_ctrl=1 after 1 cycle. Toggle both during a transaction -> outputs unchanged until the cycle after done.
- Edge: CHAIN_LEN=1, capture_en=1, update_en=1, wdata=1 -> latency 6 cycles; bsi=1 during SH_LO/SH_HI.

Source files
------------

// File: rtl/dram_bscan_chain_ctl.sv
// Boundary-scan chain initiator for the DRAM SSTL pad ring: runs one
// capture/shift/update transaction and collects the chain's serial output.
module dram_bscan_chain_ctl #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 capture_en,
    input  logic                 update_en,
    input  logic [CHAIN_LEN-1:0] wdata,
    input  logic                 ext_test,
    input  logic                 hiz_req,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 clock_dr,
    output logic                 shift_dr,
    output logic                 update_dr,
    output logic                 mode_ctrl,
    output logic                 hiz_n,
    output logic                 bsi,
    input  logic                 bso
);

    typedef enum logic [2:0] {
        StIdle, StCapLo, StCapHi, StShLo, StShHi, StUpd, StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] wreg_q, wreg_d;
    logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
    logic                 upd_en_q, upd_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 clock_dr_q, clock_dr_d;
    logic                 shift_dr_q, shift_dr_d;
    logic                 update_dr_q, update_dr_d;
    logic                 mode_q, mode_d;
    logic                 hiz_n_q, hiz_n_d;
    logic                 bsi_q, bsi_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wreg_d   = wreg_q;
        rdata_d  = rdata_q;
        upd_en_d = upd_en_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    wreg_d   = wdata;
                    upd_en_d = update_en;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    state_d  = capture_en ? StCapLo : StShLo;
                end
            end
            StCapLo: state_d = StCapHi;
            StCapHi: state_d = StShLo;
            StShLo: begin
                // bso is stable here; the chain advances on the next clock_dr rise
                for (int i = 0; i < int'(CHAIN_LEN); i++) begin
                    if (cnt_q == CNT_W'(i)) rdata_d[i] = bso;
                end
                state_d = StShHi;
            end
            StShHi: begin
                wreg_d = wreg_q >> 1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = upd_en_q ? StUpd : StDone;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StShLo;
                end
            end
            StUpd:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Strobes are registered from the next state so they change cleanly on clk
        busy_d      = !(state_d inside {StIdle, StDone});
        done_d      = (state_d == StDone);
        clock_dr_d  = (state_d inside {StCapHi, StShHi});
        shift_dr_d  = (state_d inside {StShLo, StShHi});
        update_dr_d = (state_d == StUpd);
        bsi_d       = (state_d == StShLo) ? wreg_d[0] : bsi_q;

        // Pad mode/tri-state track the requests only between transactions
        mode_d  = mode_q;
        hiz_n_d = hiz_n_q;
        if (state_q == StIdle || state_q == StDone) begin
            mode_d  = ext_test;
            hiz_n_d = ~hiz_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wreg_q      <= '0;
            rdata_q     <= '0;
            upd_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clock_dr_q  <= 1'b0;
            shift_dr_q  <= 1'b0;
            update_dr_q <= 1'b0;
            mode_q      <= 1'b0;
            hiz_n_q     <= 1'b1;
            bsi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wreg_q      <= wreg_d;
            rdata_q     <= rdata_d;
            upd_en_q    <= upd_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            clock_dr_q  <= clock_dr_d;
            shift_dr_q  <= shift_dr_d;
            update_dr_q <= update_dr_d;
            mode_q      <= mode_d;
            hiz_n_q     <= hiz_n_d;
            bsi_q       <= bsi_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign clock_dr  = clock_dr_q;
    assign shift_dr  = shift_dr_q;
    assign update_dr = update_dr_q;
    assign mode_ctrl = mode_q;
    assign hiz_n     = hiz_n_q;
    assign bsi       = bsi_q;

endmodule
